// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter
// Shares one AXI-Stream sink among 4 requesters at packet granularity.
// Round-robin arbitration happens in IDLE; the winner is locked (BUSY) until
// its TLAST beat is accepted, so a grant never changes mid-packet. The output
// is a one-deep register slice that sustains one beat per cycle.
//
// Ports:
//   ACLK        clock, rising edge
//   ARESETn     synchronous active-low reset
//   TDATA_in    packed requester data, port i at [i*DATA_W +: DATA_W]
//   TVALID_in   per-port valid
//   TLAST_in    per-port end-of-packet
//   TREADY_out  per-port ready (only the owner can be ready)
//   TDATA_out   data to shared sink
//   TVALID_out  output valid
//   TLAST_out   output end-of-packet
//   TREADY_in   ready from shared sink
//   GRANT_out   one-hot current owner, zero when IDLE
//   TID_out     owner index of the beat in the slice (only with AXIS_ARB_TID_EN)
//
// Optional feature macro: AXIS_ARB_TID_EN adds TID_out.

module axis_pkt_arbiter #(
    parameter int DATA_W = 8,
    parameter int NPORT  = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [NPORT*DATA_W-1:0] TDATA_in,
    input  logic [NPORT-1:0]        TVALID_in,
    input  logic [NPORT-1:0]        TLAST_in,
    output logic [NPORT-1:0]        TREADY_out,
    output logic [DATA_W-1:0]       TDATA_out,
    output logic                    TVALID_out,
    output logic                    TLAST_out,
    input  logic                    TREADY_in,
    output logic [NPORT-1:0]        GRANT_out
`ifdef AXIS_ARB_TID_EN
    ,
    output logic [1:0]              TID_out
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state;
    logic [1:0] owner;
    logic [1:0] last_grant;

    logic [1:0] sh;
    logic [3:0] rot;
    logic [1:0] off;
    logic [1:0] pick;
    logic       pick_ok;
    logic       slice_free;
    logic       accept;

    // Rotate the request vector so bit 0 is the port just after last_grant;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    always_comb begin
        sh      = last_grant + 2'd1;
        rot     = 4'({TVALID_in, TVALID_in} >> sh);
        pick_ok = |rot;
        casez (rot)
            4'b???1: off = 2'd0;
            4'b??10: off = 2'd1;
            4'b?100: off = 2'd2;
            4'b1000: off = 2'd3;
            default: off = 2'd0;
        endcase
        pick = sh + off;
    end

    always_comb begin
        slice_free = !TVALID_out || TREADY_in;
        if (state == BUSY) begin
            TREADY_out = GRANT_out & {NPORT{slice_free}};
        end else begin
            TREADY_out = '0;
        end
        accept = |(TVALID_in & TREADY_out);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= 2'd3;
            GRANT_out  <= '0;
            TVALID_out <= 1'b0;
            TLAST_out  <= 1'b0;
            TDATA_out  <= '0;
`ifdef AXIS_ARB_TID_EN
            TID_out    <= '0;
`endif
        end else begin
            if (state == IDLE) begin
                if (pick_ok) begin
                    state      <= BUSY;
                    owner      <= pick;
                    last_grant <= pick;
                    GRANT_out  <= {{(NPORT-1){1'b0}}, 1'b1} << pick;
                end
            end else begin
                if (accept && TLAST_in[owner]) begin
                    state     <= IDLE;
                    GRANT_out <= '0;
                end
            end

            // Register slice: load on accept, otherwise drain when the sink takes it.
            if (accept) begin
                TVALID_out <= 1'b1;
                TDATA_out  <= TDATA_in[owner*DATA_W +: DATA_W];
                TLAST_out  <= TLAST_in[owner];
`ifdef AXIS_ARB_TID_EN
                TID_out    <= owner;
`endif
            end else if (TREADY_in) begin
                TVALID_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter
// Directed bench for axis_pkt_arbiter. Per-port beat queues act as AXI-Stream
// sources; a packet-level model (round-robin winner search, owner lock until
// TLAST, one-deep output slice) predicts the outputs every cycle, and
// hand-computed literal expectations pin the observed beat/grant sequences.

module tb_axis_pkt_arbiter;

    localparam int DW = 8;

    logic            ACLK = 1'b0;
    logic            ARESETn = 1'b0;
    logic [4*DW-1:0] TDATA_in = '0;
    logic [3:0]      TVALID_in = '0;
    logic [3:0]      TLAST_in = '0;
    logic [3:0]      TREADY_out;
    logic [DW-1:0]   TDATA_out;
    logic            TVALID_out;
    logic            TLAST_out;
    logic            TREADY_in = 1'b0;
    logic [3:0]      GRANT_out;
`ifdef AXIS_ARB_TID_EN
    logic [1:0]      TID_out;
`endif

    axis_pkt_arbiter #(.DATA_W(DW), .NPORT(4)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .TDATA_in   (TDATA_in),
        .TVALID_in  (TVALID_in),
        .TLAST_in   (TLAST_in),
        .TREADY_out (TREADY_out),
        .TDATA_out  (TDATA_out),
        .TVALID_out (TVALID_out),
        .TLAST_out  (TLAST_out),
        .TREADY_in  (TREADY_in),
        .GRANT_out  (GRANT_out)
`ifdef AXIS_ARB_TID_EN
        ,
        .TID_out    (TID_out)
`endif
    );

    always #5 ACLK = ~ACLK;

    // Sources
    logic [8:0] smem [4][32];
    int head [4];
    int tail [4];

    // Model
    bit         m_busy;
    int         m_owner;
    int         m_last;
    bit         m_vout;
    bit         m_lout;
    logic [7:0] m_dout;
    int         m_tid;

    // Logs of sink-accepted beats and of new grants
    logic [7:0] ldata [128];
    logic       llast [128];
    int         lcyc  [128];
    int         ltid  [128];
    int         n_log;
    logic [3:0] glog  [128];
    int         n_g;
    logic [3:0] g_prev;

    int  cyc;
    int  n_tests;
    int  n_fail;
    bit  chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        r = '0;
        if (m_busy && (!m_vout || TREADY_in)) r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic push(input int p, input logic [7:0] d, input logic l);
        smem[p][tail[p]] = {l, d};
        tail[p]++;
    endtask

    task automatic drive_pins();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                TVALID_in[i]          = 1'b1;
                TDATA_in[i*DW +: DW]  = smem[i][head[i]][7:0];
                TLAST_in[i]           = smem[i][head[i]][8];
            end else begin
                TVALID_in[i]          = 1'b0;
                TDATA_in[i*DW +: DW]  = '0;
                TLAST_in[i]           = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        logic [3:0] r;
        bit acc;
        if (!ARESETn) begin
            m_busy = 0; m_last = 3; m_vout = 0; m_lout = 0; m_dout = '0; m_tid = 0;
        end else begin
            r   = m_ready();
            acc = m_busy && TVALID_in[m_owner] && r[m_owner];
            if (acc) begin
                m_vout = 1;
                m_dout = TDATA_in[m_owner*DW +: DW];
                m_lout = TLAST_in[m_owner];
                m_tid  = m_owner;
            end else if (TREADY_in) begin
                m_vout = 0;
            end
            if (!m_busy) begin
                for (int k = 1; k <= 4; k++) begin
                    if (!m_busy && TVALID_in[(m_last + k) % 4]) begin
                        m_owner = (m_last + k) % 4;
                        m_busy  = 1;
                    end
                end
                if (m_busy) m_last = m_owner;
            end else if (acc && TLAST_in[m_owner]) begin
                m_busy = 0;
            end
        end
    endtask

    task automatic compare();
        logic [3:0] eg;
        eg = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        chk("tready_out", TREADY_out, m_ready());
        chk("grant_out", GRANT_out, eg);
        chk("tvalid_out", TVALID_out, m_vout);
        if (m_vout) begin
            chk("tdata_out", TDATA_out, m_dout);
            chk("tlast_out", TLAST_out, m_lout);
`ifdef AXIS_ARB_TID_EN
            chk("tid_out", TID_out, m_tid);
`endif
        end
    endtask

    task automatic tick();
        logic [3:0] hs;
        @(negedge ACLK);
        hs = TVALID_in & TREADY_out;
        if (chk_en) compare();
        if (TVALID_out === 1'b1 && TREADY_in === 1'b1) begin
            ldata[n_log] = TDATA_out;
            llast[n_log] = TLAST_out;
            lcyc[n_log]  = cyc;
`ifdef AXIS_ARB_TID_EN
            ltid[n_log]  = TID_out;
`else
            ltid[n_log]  = 0;
`endif
            n_log++;
        end
        if (GRANT_out !== g_prev && GRANT_out !== 4'b0000) begin
            glog[n_g] = GRANT_out;
            n_g++;
        end
        g_prev = GRANT_out;
        @(posedge ACLK);
        model_step();
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) if (hs[i] === 1'b1) head[i]++;
        drive_pins();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) if (head[i] < tail[i]) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(all_empty() && TVALID_out === 1'b0 && GRANT_out === 4'b0000) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bl, bg, n;
        logic [7:0] d;
        n_tests = 0; n_fail = 0; chk_en = 0; cyc = 0; n_log = 0; n_g = 0; g_prev = '0;
        m_busy = 0; m_owner = 0; m_last = 3; m_vout = 0; m_lout = 0; m_dout = '0; m_tid = 0;
        for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end

        // Reset state
        ARESETn = 1'b0;
        tick();
        tick();
        chk_en = 1;
        chk("rst_tvalid", TVALID_out, 1'b0);
        chk("rst_tlast", TLAST_out, 1'b0);
        chk("rst_tdata", TDATA_out, 8'h00);
        chk("rst_tready", TREADY_out, 4'b0000);
        chk("rst_grant", GRANT_out, 4'b0000);
        ARESETn = 1'b1;
        tick();
        chk("idle_noreq_tready", TREADY_out, 4'b0000);

        // Port 1, three-beat packet, sink always ready
        bl = n_log; bg = n_g;
        TREADY_in = 1'b1;
        push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
        drive_pins();
        wait_idle("p1_pkt_done", 30);
        chk("p1_count", n_log - bl, 3);
        chk("p1_d0", ldata[bl], 8'h11);
        chk("p1_d1", ldata[bl+1], 8'h22);
        chk("p1_d2", ldata[bl+2], 8'h33);
        chk("p1_l0", llast[bl], 1'b0);
        chk("p1_l1", llast[bl+1], 1'b0);
        chk("p1_l2", llast[bl+2], 1'b1);
        chk("p1_consec01", lcyc[bl+1] - lcyc[bl], 1);
        chk("p1_consec12", lcyc[bl+2] - lcyc[bl+1], 1);
        chk("p1_grant", glog[bg], 4'b0010);

        // All four ports with back-to-back single-beat packets
        do_reset();
        bl = n_log; bg = n_g;
        for (int p = 0; p < 4; p++) begin
            push(p, 8'hA0 + 8'(p), 1);
            push(p, 8'hB0 + 8'(p), 1);
        end
        drive_pins();
        wait_idle("rr_done", 60);
        chk("rr_count", n_log - bl, 8);
        chk("rr_g0", glog[bg],   4'b0001);
        chk("rr_g1", glog[bg+1], 4'b0010);
        chk("rr_g2", glog[bg+2], 4'b0100);
        chk("rr_g3", glog[bg+3], 4'b1000);
        chk("rr_g4", glog[bg+4], 4'b0001);
        chk("rr_d0", ldata[bl],   8'hA0);
        chk("rr_d3", ldata[bl+3], 8'hA3);
        chk("rr_d4", ldata[bl+4], 8'hB0);
        chk("rr_gap1", lcyc[bl+1] - lcyc[bl], 2);
        chk("rr_gap4", lcyc[bl+4] - lcyc[bl+3], 2);

        // Port 0 mid-packet, sink stalls for five cycles
        do_reset();
        bl = n_log;
        push(0, 8'h01, 0); push(0, 8'h02, 0); push(0, 8'h03, 0); push(0, 8'h04, 1);
        drive_pins();
        n = 0;
        while (TVALID_out !== 1'b1 && n < 10) begin tick(); n++; end
        chk("stall_reach_valid", 32'(n < 10), 32'd1);
        TREADY_in = 1'b0;
        d = TDATA_out;
        chk("stall_first", d, 8'h01);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", TDATA_out, 8'h01);
            chk("stall_ready0", TREADY_out[0], 1'b0);
        end
        TREADY_in = 1'b1;
        wait_idle("stall_done", 30);
        chk("stall_count", n_log - bl, 4);
        for (int i = 0; i < 4; i++) chk("stall_seq", ldata[bl+i], 8'(i + 1));

        // Port 2 streaming while port 3 requests
        do_reset();
        bl = n_log; bg = n_g;
        push(2, 8'h51, 0); push(2, 8'h52, 0); push(2, 8'h53, 0); push(2, 8'h54, 1);
        drive_pins();
        tick();
        tick();
        push(3, 8'h61, 1);
        drive_pins();
        n = 0;
        while (GRANT_out === 4'b0100 && n < 20) begin
            chk("holdoff_ready3", TREADY_out[3], 1'b0);
            tick();
            n++;
        end
        wait_idle("holdoff_done", 30);
        chk("holdoff_g0", glog[bg], 4'b0100);
        chk("holdoff_g1", glog[bg+1], 4'b1000);
        chk("holdoff_count", n_log - bl, 5);
        chk("holdoff_last_p2", ldata[bl+3], 8'h54);
        chk("holdoff_p3", ldata[bl+4], 8'h61);

        // Reset on the second beat of a four-beat port-1 packet
        do_reset();
        push(1, 8'h71, 0); push(1, 8'h72, 0); push(1, 8'h73, 0); push(1, 8'h74, 1);
        drive_pins();
        tick();
        tick();
        ARESETn = 1'b0;
        tail[1] = head[1];
        drive_pins();
        tick();
        chk("midrst_tvalid", TVALID_out, 1'b0);
        chk("midrst_grant", GRANT_out, 4'b0000);
        chk("midrst_tready", TREADY_out, 4'b0000);
        ARESETn = 1'b1;
        bl = n_log; bg = n_g;
        push(0, 8'h91, 1);
        push(2, 8'hA2, 1);
        drive_pins();
        wait_idle("midrst_done", 30);
        chk("midrst_count", n_log - bl, 2);
        chk("midrst_d0", ldata[bl], 8'h91);
        chk("midrst_d1", ldata[bl+1], 8'hA2);
        chk("midrst_g0", glog[bg], 4'b0001);
        chk("midrst_g1", glog[bg+1], 4'b0100);

`ifdef AXIS_ARB_TID_EN
        // Port-3 packet carries owner index 3
        do_reset();
        bl = n_log;
        push(3, 8'hC1, 0); push(3, 8'hC2, 1);
        drive_pins();
        wait_idle("tid_done", 30);
        chk("tid_count", n_log - bl, 2);
        chk("tid_b0", ltid[bl], 3);
        chk("tid_b1", ltid[bl+1], 3);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
